// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared defaults, FSM state encoding and PC-select codes for the fetch sequencer
// Holds the default address/instruction widths and the reset and trap vectors. It also holds the
// fetch FSM state encoding and the select codes that the FSM drives into the next-PC mux.
package fetch_sequencer_pkg;
    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_INST_WIDTH = 16;
    localparam int DEF_INST_BYTES = 2;
    localparam logic [15:0] DEF_RESET_VECTOR = 16'h0000;
    localparam logic [15:0] DEF_TRAP_VECTOR = 16'h0004;
    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2,
        S_DRAIN = 2'd3
    } fetch_state_e;
    typedef enum logic [1:0] {
        PC_HOLD  = 2'd0,
        PC_INC   = 2'd1,
        PC_REDIR = 2'd2,
        PC_RESET = 2'd3
    } pc_sel_e;
endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: instruction-memory req/ack bus plus decode valid/ready bus
// Ports (modport master = fetch sequencer, slave = memory/decode side):
//   imem_req, imem_addr      fetch request and its address, held until imem_ack
//   imem_ack, imem_rdata     memory response strobe and the fetched word
//   inst, inst_valid         registered instruction offered to decode
//   inst_ready               decode accepts inst when inst_valid & inst_ready
interface fetch_sequencer_if
    import fetch_sequencer_pkg::*;
#(
    parameter int AW = DEF_ADDR_WIDTH,
    parameter int IW = DEF_INST_WIDTH
) ();
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [IW-1:0] imem_rdata;
    logic [IW-1:0] inst;
    logic          inst_valid;
    logic          inst_ready;
    modport master (
        output imem_req, imem_addr, inst, inst_valid,
        input  imem_ack, imem_rdata, inst_ready
    );
    modport slave (
        input  imem_req, imem_addr, inst, inst_valid,
        output imem_ack, imem_rdata, inst_ready
    );
endinterface

// File: rtl/fetch_sequencer_next_pc_mux.sv
// fetch_next_pc_mux: combinational next-PC select (hold / increment / redirect / reset) with alignment check
// Optional feature macro: FETCH_ALIGN_TRAP_EN. When it is defined, an odd redirect target becomes
// TRAP_VECTOR and raises o_fault. When it is undefined, bit 0 of the target is cleared and o_fault stays 0.
// Ports:
//   i_sel      select code from the FSM
//   i_pc_cur   current PC
//   i_target   redirect destination
//   o_pc_next  next PC value
//   o_fault    misaligned redirect taken this cycle
module fetch_next_pc_mux
    import fetch_sequencer_pkg::*;
#(
    parameter int AW = DEF_ADDR_WIDTH,
    parameter int INST_BYTES = DEF_INST_BYTES,
    parameter logic [AW-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [AW-1:0] TRAP_VECTOR = DEF_TRAP_VECTOR
) (
    input  pc_sel_e       i_sel,
    input  logic [AW-1:0] i_pc_cur,
    input  logic [AW-1:0] i_target,
    output logic [AW-1:0] o_pc_next,
    output logic          o_fault
);
`ifdef FETCH_ALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif
    logic          w_misalign;
    logic [AW-1:0] w_target;
    assign w_misalign = i_target[0];
    assign w_target = !w_misalign ? i_target : TRAP_EN ? TRAP_VECTOR : {i_target[AW-1:1], 1'b0};
    assign o_fault = TRAP_EN && i_sel == PC_REDIR && w_misalign;
    // The increment wraps modulo 2^AW by truncation.
    always_comb begin
        o_pc_next = i_sel == PC_RESET ? RESET_VECTOR :
                    i_sel == PC_INC   ? i_pc_cur + AW'(INST_BYTES) :
                    i_sel == PC_REDIR ? w_target : i_pc_cur;
    end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC sequencing, instruction-memory handshake and decode hand-off with redirects and stalls
// Optional feature macro: FETCH_ALIGN_TRAP_EN. It makes a misaligned redirect go to TRAP_VECTOR and pulse o_fetch_fault.
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   i_pc_cur            current PC read back from the external PC register
//   o_pc_next           next PC to the PC register, which loads it on every clock
//   i_redirect_valid    one-cycle branch/jump redirect request
//   i_redirect_target   redirect destination
//   o_fetch_fault       one-cycle pulse on a misaligned redirect
//   bus                 memory req/ack and decode valid/ready (master side)
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int INST_ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int INST_WIDTH = DEF_INST_WIDTH,
    parameter int INST_BYTES = DEF_INST_BYTES,
    parameter logic [INST_ADDR_WIDTH-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [INST_ADDR_WIDTH-1:0] TRAP_VECTOR = DEF_TRAP_VECTOR
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [INST_ADDR_WIDTH-1:0] i_pc_cur,
    output logic [INST_ADDR_WIDTH-1:0] o_pc_next,
    input  logic                       i_redirect_valid,
    input  logic [INST_ADDR_WIDTH-1:0] i_redirect_target,
    output logic                       o_fetch_fault,
    fetch_sequencer_if.master          bus
);
    fetch_state_e               r_state;
    fetch_state_e               w_state_nxt;
    logic [INST_WIDTH-1:0]      r_inst;
    logic [INST_ADDR_WIDTH-1:0] r_drain_addr;
    pc_sel_e                    w_sel;
    logic                       w_load_inst;
    logic                       w_load_drain;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_BOOT;
            r_inst       <= '0;
            r_drain_addr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_inst)
                r_inst <= bus.imem_rdata;
            if (w_load_drain)
                r_drain_addr <= i_pc_cur;
        end
    end
    // A redirect outranks ack and ready. An in-flight request is never abandoned: it is drained at
    // its old address while the PC already holds the redirect target.
    always_comb begin
        w_state_nxt  = r_state;
        w_sel        = PC_HOLD;
        w_load_inst  = 1'b0;
        w_load_drain = 1'b0;
        if (!rst_n)
            w_sel = PC_RESET;
        else begin
            case (r_state)
                S_BOOT: begin
                    w_sel       = PC_RESET;
                    w_state_nxt = S_FETCH;
                end
                S_FETCH: begin
                    if (i_redirect_valid) begin
                        w_sel        = PC_REDIR;
                        w_state_nxt  = bus.imem_ack ? S_FETCH : S_DRAIN;
                        w_load_drain = !bus.imem_ack;
                    end else if (bus.imem_ack) begin
                        w_sel       = PC_INC;
                        w_load_inst = 1'b1;
                        w_state_nxt = S_VALID;
                    end
                end
                S_VALID: begin
                    if (i_redirect_valid) begin
                        w_sel       = PC_REDIR;
                        w_state_nxt = S_FETCH;
                    end else if (bus.inst_ready)
                        w_state_nxt = S_FETCH;
                end
                S_DRAIN: begin
                    if (i_redirect_valid)
                        w_sel = PC_REDIR;
                    if (bus.imem_ack)
                        w_state_nxt = S_FETCH;
                end
                default: w_state_nxt = S_BOOT;
            endcase
        end
    end
    fetch_next_pc_mux #(
        .AW(INST_ADDR_WIDTH),
        .INST_BYTES(INST_BYTES),
        .RESET_VECTOR(RESET_VECTOR),
        .TRAP_VECTOR(TRAP_VECTOR)
    ) u_next_pc (
        .i_sel(w_sel),
        .i_pc_cur(i_pc_cur),
        .i_target(i_redirect_target),
        .o_pc_next(o_pc_next),
        .o_fault(o_fetch_fault)
    );
    assign bus.imem_req   = r_state == S_FETCH || r_state == S_DRAIN;
    assign bus.imem_addr  = r_state == S_DRAIN ? r_drain_addr : i_pc_cur;
    assign bus.inst       = r_inst;
    assign bus.inst_valid = r_state == S_VALID;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: scoreboard bench for fetch_sequencer with a PC register and a behavioural imem
// The behavioural imem returns addr ^ 16'hBEEF after a programmable number of wait cycles.
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;
`ifdef FETCH_ALIGN_TRAP_EN
    localparam logic [15:0] T6_PCN = 16'h0004;
    localparam logic [15:0] T6_FAULT = 16'h0001;
    localparam logic [15:0] T6_INST = 16'hBEEB;
    localparam logic [15:0] T7_ADDR = 16'h0006;
`else
    localparam logic [15:0] T6_PCN = 16'h0030;
    localparam logic [15:0] T6_FAULT = 16'h0000;
    localparam logic [15:0] T6_INST = 16'hBEDF;
    localparam logic [15:0] T7_ADDR = 16'h0032;
`endif
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pc_cur;
    logic [15:0] pc_next;
    logic        redir = 1'b0;
    logic [15:0] redir_tgt = '0;
    logic        fault;
    int          ack_delay = 0;
    int          cnt;
    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_addr[$];
    logic [15:0] exp_inst[$];
    logic        busy = 1'b0;
    logic [15:0] req_addr = '0;

    fetch_sequencer_if #(.AW(16), .IW(16)) bus ();

    fetch_sequencer dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_pc_cur(pc_cur),
        .o_pc_next(pc_next),
        .i_redirect_valid(redir),
        .i_redirect_target(redir_tgt),
        .o_fetch_fault(fault),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) pc_cur <= pc_next;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.imem_ack   <= 1'b0;
            bus.imem_rdata <= '0;
            cnt            <= 0;
        end else if (bus.imem_req && !bus.imem_ack) begin
            if (cnt >= ack_delay) begin
                bus.imem_ack   <= 1'b1;
                bus.imem_rdata <= bus.imem_addr ^ 16'hBEEF;
                cnt            <= 0;
            end else
                cnt <= cnt + 1;
        end else begin
            bus.imem_ack <= 1'b0;
            cnt          <= 0;
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n)
            busy <= 1'b0;
        else begin
            if (bus.imem_req && !busy) begin
                chk("addr_expected", 16'(exp_addr.size() != 0), 16'd1);
                if (exp_addr.size() != 0)
                    chk("fetch_addr", bus.imem_addr, exp_addr.pop_front());
                req_addr <= bus.imem_addr;
                busy     <= 1'b1;
            end
            if (bus.imem_ack) begin
                chk("addr_stable", bus.imem_addr, req_addr);
                busy <= 1'b0;
            end
            if (bus.inst_valid && bus.inst_ready && !redir) begin
                chk("inst_expected", 16'(exp_inst.size() != 0), 16'd1);
                if (exp_inst.size() != 0)
                    chk("inst", bus.inst, exp_inst.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit cond(input int which, input logic [15:0] v);
        return which == 0 ? (bus.inst_valid && pc_cur == v) :
               which == 1 ? (bus.imem_req && bus.imem_addr == v) :
               which == 2 ? (bus.imem_ack === 1'b1) :
               (exp_addr.size() == 0 && exp_inst.size() == 0);
    endfunction

    task automatic wait_cond(input int which, input logic [15:0] v, input int max, input string name);
        int n = 0;
        while (!cond(which, v) && n < max) begin
            step();
            n++;
        end
        chk(name, 16'(cond(which, v)), 16'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.inst_ready = 1'b1;
        #20;
        chk("rst_pc_next", pc_next, 16'h0000);
        chk("rst_req", 16'(bus.imem_req), 16'd0);
        chk("rst_valid", 16'(bus.inst_valid), 16'd0);
        chk("rst_inst", bus.inst, 16'h0000);
        chk("rst_fault", 16'(fault), 16'd0);
        exp_addr = '{16'h0000, 16'h0002, 16'h0004};
        exp_inst = '{16'hBEEF, 16'hBEED};
        #14 rst_n = 1'b1;
        // redirect while an instruction is offered and decode is ready: it is dropped
        wait_cond(0, 16'h0006, 40, "t3_wait_valid");
        exp_addr.push_back(16'h0014);
        exp_addr.push_back(16'h0016);
        exp_inst.push_back(16'hBEFB);
        exp_inst.push_back(16'hBEF9);
        redir = 1'b1;
        redir_tgt = 16'h0014;
        step();
        redir = 1'b0;
        bus.inst_ready = 1'b0;
        chk("t3_valid_drop", 16'(bus.inst_valid), 16'd0);
        // decode stall of 5 cycles, accepted on the 6th
        wait_cond(0, 16'h0016, 20, "t2_wait_valid");
        for (int i = 0; i < 5; i++) begin
            chk("t2_inst_hold", bus.inst, 16'hBEFB);
            chk("t2_pc_hold", pc_cur, 16'h0016);
            chk("t2_req_low", 16'(bus.imem_req), 16'd0);
            chk("t2_valid_hold", 16'(bus.inst_valid), 16'd1);
            step();
        end
        bus.inst_ready = 1'b1;
        ack_delay = 3;
        exp_addr.push_back(16'h0018);
        exp_addr.push_back(16'h0040);
        exp_inst.push_back(16'hBEAF);
        step();
        chk("t2_valid_after", 16'(bus.inst_valid), 16'd0);
        chk("t2_req_after", 16'(bus.imem_req), 16'd1);
        // redirect in the first wait cycle of a slow fetch: old address drained, data dropped
        wait_cond(1, 16'h0018, 40, "t4_wait_req");
        redir = 1'b1;
        redir_tgt = 16'h0040;
        step();
        redir = 1'b0;
        chk("t4_addr_held", bus.imem_addr, 16'h0018);
        chk("t4_req_held", 16'(bus.imem_req), 16'd1);
        chk("t4_pc_target", pc_cur, 16'h0040);
        wait_cond(2, 16'h0000, 10, "t4_wait_ack");
        chk("t4_ack_addr", bus.imem_addr, 16'h0018);
        ack_delay = 0;
        // PC wrap at the top of the address space
        exp_addr.push_back(16'h0042);
        exp_addr.push_back(16'hFFFE);
        exp_addr.push_back(16'h0000);
        exp_inst.push_back(16'h4111);
        wait_cond(0, 16'h0044, 40, "t5_wait_valid");
        redir = 1'b1;
        redir_tgt = 16'hFFFE;
        step();
        redir = 1'b0;
        wait_cond(2, 16'h0000, 10, "t5_wait_ack");
        chk("t5_pc_held", pc_cur, 16'hFFFE);
        chk("t5_wrap", pc_next, 16'h0000);
        // misaligned redirect
        exp_addr.push_back(T6_PCN);
        exp_inst.push_back(T6_INST);
        wait_cond(0, 16'h0002, 40, "t6_wait_valid");
        redir = 1'b1;
        redir_tgt = 16'h0031;
        #1;
        chk("t6_pc_next", pc_next, T6_PCN);
        chk("t6_fault", 16'(fault), T6_FAULT);
        step();
        redir = 1'b0;
        #1;
        chk("t6_fault_end", 16'(fault), 16'd0);
        ack_delay = 3;
        // reset asserted while draining
        exp_addr.push_back(T7_ADDR);
        exp_addr.push_back(16'h0000);
        exp_inst.push_back(16'hBEEF);
        wait_cond(1, T7_ADDR, 40, "t7_wait_req");
        redir = 1'b1;
        redir_tgt = 16'h0100;
        step();
        redir = 1'b0;
        chk("t7_drain_addr", bus.imem_addr, T7_ADDR);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_rst_pc_next", pc_next, 16'h0000);
        chk("t7_rst_req", 16'(bus.imem_req), 16'd0);
        chk("t7_rst_valid", 16'(bus.inst_valid), 16'd0);
        chk("t7_rst_inst", bus.inst, 16'h0000);
        chk("t7_rst_fault", 16'(fault), 16'd0);
        ack_delay = 0;
        step();
        step();
        #2 rst_n = 1'b1;
        wait_cond(3, 16'h0000, 60, "scoreboard_drained");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
